// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks (read and write side).
// Gray/binary conversion works on any pointer width up to FIFO_PTR_W_MAX.
package fifo_pkg;

  localparam int FIFO_SYNC_STAGES_MIN = 2;
  localparam int FIFO_PTR_W_MAX       = 32;

  typedef logic [FIFO_PTR_W_MAX-1:0] fifo_ptr_t;

  function automatic fifo_ptr_t width_mask(input int width);
    fifo_ptr_t mask;
    if (width >= FIFO_PTR_W_MAX) mask = '1;
    else                         mask = (fifo_ptr_t'(1) << width) - fifo_ptr_t'(1);
    return mask;
  endfunction

  function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin, input int width);
    fifo_ptr_t b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Bits above the live width are masked to zero, so they drop out of the XOR chain.
  function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray, input int width);
    fifo_ptr_t g;
    fifo_ptr_t b;
    g = gray & width_mask(width);
    b = '0;
    b[FIFO_PTR_W_MAX-1] = g[FIFO_PTR_W_MAX-1];
    for (int i = FIFO_PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-bit flop-chain synchroniser for a Gray-coded pointer crossing clock domains.
// No logic between stages and no enable: only valid for inputs that change one bit at a time.
module gray_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < FIFO_SYNC_STAGES_MIN) begin : g_bad_stages
    $error("gray_sync: STAGES must be at least %0d", FIFO_SYNC_STAGES_MIN);
  end

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr.sv
// Read-side pointer controller of a dual-clock FIFO: synchronises the write pointer,
// keeps the binary/Gray read pointer and derives empty, level and underflow.
module fifo_rd_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH:0]   wr_gray_i,
  input  logic                  rd_en_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH:0]   rd_gray_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  underflow_o
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_gray_sync;
  logic [PTR_W-1:0] wr_bin_d,  wr_bin_q;
  logic [PTR_W-1:0] rd_bin_d,  rd_bin_q;
  logic [PTR_W-1:0] rd_gray_d, rd_gray_q;
  logic             underflow_d, underflow_q;
  logic             empty;
  logic             rd_accept;

  gray_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (wr_gray_i),
    .q_o    (wr_gray_sync)
  );

  assign empty     = (rd_bin_q == wr_bin_q);
  assign rd_accept = rd_en_i && !empty;

  // Gray read pointer is loaded from the next binary value so the exported
  // pointer is glitch-free and moves exactly one bit per accepted read.
  always_comb begin
    wr_bin_d    = PTR_W'(gray2bin(fifo_ptr_t'(wr_gray_sync), PTR_W));
    rd_bin_d    = rd_bin_q;
    if (rd_accept) begin
      rd_bin_d = rd_bin_q + PTR_W'(1);
    end
    rd_gray_d   = PTR_W'(bin2gray(fifo_ptr_t'(rd_bin_d), PTR_W));
    underflow_d = rd_en_i && empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bin_q    <= '0;
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_addr_o   = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_gray_o   = rd_gray_q;
  assign empty_o     = empty;
  assign level_o     = wr_bin_q - rd_bin_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr.sv
// Bench for fifo_rd_ptr: directed vector table, hand sequences for depth/reset,
// and a randomized stream checked against a delay-line occupancy model.
module tb_fifo_rd_ptr;

  localparam int AW    = 4;
  localparam int SYNC  = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AW:0]   wr_gray_i;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_o;
  logic [AW:0]   rd_gray_o;
  logic          empty_o;
  logic [AW:0]   level_o;
  logic          underflow_o;

  fifo_rd_ptr #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wr_gray_i   (wr_gray_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_o   (rd_addr_o),
    .rd_gray_o   (rd_gray_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: occupancy counts plus a delay line standing in for the CDC path.
  int   wr_ptr;
  int   m_rd;
  int   m_wvis;
  bit   m_uf;
  bit   m_acc;
  int   pipe[$];
  logic [AW:0] prev_gray;

  typedef struct {
    logic rd_en;
    int   wr;
    logic e_empty;
    int   e_level;
    int   e_addr;
    int   e_gray;
    logic e_uf;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [AW:0] to_gray(input int b);
    int m;
    m = b % PMOD;
    return (AW+1)'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    wr_ptr = 0;
    m_rd   = 0;
    m_wvis = 0;
    m_uf   = 0;
    m_acc  = 0;
    pipe.delete();
    for (int i = 0; i < SYNC; i++) pipe.push_back(0);
    prev_gray = '0;
  endtask

  // One read-clock cycle: drive at negedge, model the edge, check at next negedge.
  task automatic cycle(input logic re, input int wr);
    bit m_empty;
    rd_en_i   = re;
    wr_ptr    = wr;
    wr_gray_i = to_gray(wr);
    @(posedge clk_i);
    m_empty = (m_rd == m_wvis);
    m_acc   = re && !m_empty;
    m_uf    = re && m_empty;
    if (m_acc) m_rd = (m_rd + 1) % PMOD;
    pipe.push_back(wr % PMOD);
    m_wvis = pipe.pop_front();
    @(negedge clk_i);
    if (m_acc) chk("gray_hamming", $countones(rd_gray_o ^ prev_gray), 1);
    prev_gray = rd_gray_o;
    chk("m_rd_addr",   int'(rd_addr_o),   m_rd % DEPTH);
    chk("m_rd_gray",   int'(rd_gray_o),   int'(to_gray(m_rd)));
    chk("m_empty",     int'(empty_o),     int'(m_rd == m_wvis));
    chk("m_level",     int'(level_o),     (m_wvis - m_rd + PMOD) % PMOD);
    chk("m_underflow", int'(underflow_o), int'(m_uf));
    chk("level_le_depth", int'(level_o <= DEPTH), 1);
  endtask

  initial begin
    //           rd_en  wr  empty lvl addr gray uf
    tbl[0]  = '{1'b1, 0, 1'b1, 0, 0, 0, 1'b1};
    tbl[1]  = '{1'b1, 0, 1'b1, 0, 0, 0, 1'b1};
    tbl[2]  = '{1'b0, 1, 1'b1, 0, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 1, 1'b1, 0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0, 1, 1'b0, 1, 0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1, 1'b1, 0, 1, 1, 1'b0};
    tbl[6]  = '{1'b0, 1, 1'b1, 0, 1, 1, 1'b0};
    tbl[7]  = '{1'b0, 2, 1'b1, 0, 1, 1, 1'b0};
    tbl[8]  = '{1'b0, 2, 1'b1, 0, 1, 1, 1'b0};
    tbl[9]  = '{1'b0, 3, 1'b0, 1, 1, 1, 1'b0};
    tbl[10] = '{1'b0, 3, 1'b0, 1, 1, 1, 1'b0};
    tbl[11] = '{1'b1, 3, 1'b0, 1, 2, 3, 1'b0};
    tbl[12] = '{1'b1, 3, 1'b1, 0, 3, 2, 1'b0};
    tbl[13] = '{1'b1, 3, 1'b1, 0, 3, 2, 1'b1};
    tbl[14] = '{1'b0, 3, 1'b1, 0, 3, 2, 1'b0};

    rst_ni    = 1'b0;
    rd_en_i   = 1'b0;
    wr_gray_i = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("reset_empty", int'(empty_o), 1);
    chk("reset_level", int'(level_o), 0);
    chk("reset_addr",  int'(rd_addr_o), 0);
    chk("reset_gray",  int'(rd_gray_o), 0);
    chk("reset_uf",    int'(underflow_o), 0);

    // Directed vectors: underflow, write latency, single read, simultaneous read+write.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rd_en, tbl[i].wr);
      chk($sformatf("tbl%0d_empty", i), int'(empty_o),     int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_level", i), int'(level_o),     tbl[i].e_level);
      chk($sformatf("tbl%0d_addr",  i), int'(rd_addr_o),   tbl[i].e_addr);
      chk($sformatf("tbl%0d_gray",  i), int'(rd_gray_o),   tbl[i].e_gray);
      chk($sformatf("tbl%0d_uf",    i), int'(underflow_o), int'(tbl[i].e_uf));
    end

    // Full depth: write side advances by 16, then drain back-to-back.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 3 + i);
    repeat (SYNC + 1) cycle(1'b0, 3 + DEPTH);
    chk("full_level", int'(level_o), DEPTH);
    chk("full_empty", int'(empty_o), 0);
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1'b1, 3 + DEPTH);
      chk($sformatf("drain%0d_level", k), int'(level_o), DEPTH - k);
      chk($sformatf("drain%0d_empty", k), int'(empty_o), int'(k == DEPTH));
    end

    // Asynchronous reset mid-stream at level 5, applied between clock edges.
    for (int i = 1; i <= 5; i++) cycle(1'b0, wr_ptr + 1);
    repeat (SYNC + 1) cycle(1'b0, wr_ptr);
    chk("pre_rst_level", int'(level_o), 5);
    #2;
    rst_ni    = 1'b0;
    wr_gray_i = '0;
    #1;
    chk("arst_empty", int'(empty_o), 1);
    chk("arst_level", int'(level_o), 0);
    chk("arst_addr",  int'(rd_addr_o), 0);
    chk("arst_gray",  int'(rd_gray_o), 0);
    chk("arst_uf",    int'(underflow_o), 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(1'b1, 0);

    // Randomized stream with a legal write side; long enough to wrap the pointers.
    for (int c = 0; c < 400; c++) begin
      int nw;
      nw = wr_ptr;
      if ($urandom_range(0, 9) < 6 && ((wr_ptr - m_rd + 4 * PMOD) % PMOD) < DEPTH) nw = wr_ptr + 1;
      cycle(logic'($urandom_range(0, 9) < 5), nw);
    end
    repeat (DEPTH + SYNC + 4) cycle(1'b1, wr_ptr);
    chk("final_empty", int'(empty_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
